// File: rtl/frog_game_pkg.sv
// Shared encodings and grid constants for the Frogger-style game-control slice.
package frog_game_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_HIT  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam int GRID_COLS = 20;
  localparam int GRID_ROWS = 15;

  // Bits needed to index n cells; never less than one.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int COL_W = idx_w(GRID_COLS);
  localparam int ROW_W = idx_w(GRID_ROWS);

endpackage

// File: rtl/frog_player_pos.sv
// Player grid position: one clamped move per cycle, vertical before horizontal.
module frog_player_pos
  import frog_game_pkg::*;
#(
  parameter int COLS      = GRID_COLS,
  parameter int ROWS      = GRID_ROWS,
  parameter int START_COL = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             freeze,
  input  logic             respawn,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row
);

  localparam logic [COL_W-1:0] MAX_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] MAX_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] SPAWN_C = COL_W'(START_COL);

  always_ff @(posedge clk) begin
    if (reset || respawn) begin
      col <= SPAWN_C;
      row <= MAX_ROW;
    end else if (!freeze) begin
      // A single vertical request blocks horizontal even when it is clamped away.
      if (up ^ down) begin
        if (up && row != '0)           row <= row - 1'b1;
        else if (down && row != MAX_ROW) row <= row + 1'b1;
      end else if (left ^ right) begin
        if (left && col != '0)            col <= col - 1'b1;
        else if (right && col != MAX_COL) col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frog_game_ctrl.sv
// Game FSM, score, lives and post-hit freeze timer; position lives in frog_player_pos.
module frog_game_ctrl
  import frog_game_pkg::*;
#(
  parameter int COLS      = GRID_COLS,
  parameter int ROWS      = GRID_ROWS,
  parameter int START_COL = 9,
  parameter int LIVES     = 3,
  parameter int WIN_SCORE = 10,
  parameter int HIT_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             tick,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  output logic [ROW_W-1:0] row_sel,
  input  logic [COLS-1:0]  row_data,
  output logic [COL_W-1:0] player_col,
  output logic [ROW_W-1:0] player_row,
  output logic [1:0]       state,
  output logic [3:0]       score,
  output logic [1:0]       lives,
  output logic             win
);

  state_t     st, st_nx;
  logic [3:0] score_nx, hit_cnt, hit_nx;
  logic [1:0] lives_nx;
  logic       win_nx, freeze, respawn, collide;

  assign row_sel = player_row;
  assign state   = st;
  assign collide = row_data[player_col];

  frog_player_pos #(
    .COLS(COLS), .ROWS(ROWS), .START_COL(START_COL)
  ) u_pos (
    .clk    (clk),
    .reset  (reset),
    .up     (btn_up),
    .down   (btn_down),
    .left   (btn_left),
    .right  (btn_right),
    .freeze (freeze),
    .respawn(respawn),
    .col    (player_col),
    .row    (player_row)
  );

  always_comb begin
    st_nx    = st;
    score_nx = score;
    lives_nx = lives;
    win_nx   = win;
    hit_nx   = hit_cnt;
    freeze   = 1'b1;
    respawn  = 1'b0;
    case (st)
      S_IDLE: if (start) st_nx = S_PLAY;
      S_PLAY: begin
        if (collide) begin
          st_nx    = S_HIT;
          lives_nx = lives - 1'b1;
          hit_nx   = '0;
        end else if (player_row == '0) begin
          score_nx = score + 1'b1;
          respawn  = 1'b1;
          if (score_nx == 4'(WIN_SCORE)) begin
            st_nx  = S_DONE;
            win_nx = 1'b1;
          end
        end else begin
          freeze = 1'b0;
        end
      end
      S_HIT: begin
        // The entry edge belongs to PLAY, so a tick coincident with it is never counted.
        if (tick) begin
          hit_nx = hit_cnt + 1'b1;
          if (hit_nx == 4'(HIT_TICKS)) begin
            if (lives == '0) begin
              st_nx  = S_DONE;
              win_nx = 1'b0;
            end else begin
              st_nx   = S_PLAY;
              respawn = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= S_IDLE;
      score   <= '0;
      lives   <= 2'(LIVES);
      win     <= 1'b0;
      hit_cnt <= '0;
    end else begin
      st      <= st_nx;
      score   <= score_nx;
      lives   <= lives_nx;
      win     <= win_nx;
      hit_cnt <= hit_nx;
    end
  end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Randomized and directed bench for frog_game_ctrl against a rule-level game model.
module tb_frog_game_ctrl;

  localparam int COLS = 20, ROWS = 15, SCOL = 9, NLIVES = 3, WINS = 10, HT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, tick = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [3:0]  row_sel, player_row, score;
  logic [4:0]  player_col;
  logic [1:0]  state, lives;
  logic        win;
  logic [19:0] row_data;
  logic [19:0] obs [16];
  logic [17:0] dut_vec;

  int checks = 0, errors = 0;
  int m_state, m_col, m_row, m_score, m_lives, m_win, m_hc;

  always #5 clk = ~clk;

  assign row_data = obs[row_sel];
  assign dut_vec  = {state, player_col, player_row, score, lives, win};

  frog_game_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .row_sel(row_sel), .row_data(row_data),
    .player_col(player_col), .player_row(player_row),
    .state(state), .score(score), .lives(lives), .win(win)
  );

  // Model states: 0 idle, 1 play, 2 frozen after hit, 3 over.
  task automatic mstep(input bit st, tk, u, d, l, r, rs);
    if (rs) begin
      m_state = 0; m_col = SCOL; m_row = ROWS - 1;
      m_score = 0; m_lives = NLIVES; m_win = 0; m_hc = 0;
      return;
    end
    case (m_state)
      0: if (st) m_state = 1;
      1: begin
        if (obs[m_row][m_col]) begin
          m_lives--; m_hc = 0; m_state = 2;
        end else if (m_row == 0) begin
          m_score++; m_col = SCOL; m_row = ROWS - 1;
          if (m_score == WINS) begin m_state = 3; m_win = 1; end
        end else if (u != d) begin
          if (u && m_row > 0) m_row--;
          if (d && m_row < ROWS - 1) m_row++;
        end else if (l != r) begin
          if (l && m_col > 0) m_col--;
          if (r && m_col < COLS - 1) m_col++;
        end
      end
      2: if (tk) begin
        m_hc++;
        if (m_hc == HT) begin
          if (m_lives == 0) begin m_state = 3; m_win = 0; end
          else begin m_state = 1; m_col = SCOL; m_row = ROWS - 1; end
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [17:0] exp_vec();
    return {2'(m_state), 5'(m_col), 4'(m_row), 4'(m_score), 2'(m_lives), 1'(m_win)};
  endfunction

  function automatic logic [17:0] vec(int s, c, r, sc, lv, w);
    return {2'(s), 5'(c), 4'(r), 4'(sc), 2'(lv), 1'(w)};
  endfunction

  task automatic cyc(input bit st, tk, u, d, l, r, rs);
    start = st; tick = tk; btn_up = u; btn_down = d; btn_left = l; btn_right = r; reset = rs;
    @(posedge clk);
    mstep(st, tk, u, d, l, r, rs);
    #1;
    start = 0; tick = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; reset = 0;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 16; i++) obs[i] = '0;
  endtask

  task automatic test_reset();
    clear_obs();
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (dut_vec !== vec(0, 9, 14, 0, 3, 0)) begin
      errors++; $display("FAIL reset_values got %h want %h", dut_vec, vec(0, 9, 14, 0, 3, 0));
    end
    for (int i = 0; i < 100; i++) cyc(0, $urandom_range(0, 1), 1, 0, 1, 0, 0);
    checks++;
    if (dut_vec !== vec(0, 9, 14, 0, 3, 0)) begin
      errors++; $display("FAIL idle_hold got %h want %h", dut_vec, vec(0, 9, 14, 0, 3, 0));
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== vec(1, 9, 14, 0, 3, 0)) begin
      errors++; $display("FAIL start_play got %h want %h", dut_vec, vec(1, 9, 14, 0, 3, 0));
    end
  endtask

  task automatic test_move_clamp();
    clear_obs();
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (player_col !== 5'((8 - i < 0) ? 0 : 8 - i)) begin
        errors++; $display("FAIL left_step%0d got %0d want %0d", i, player_col, (8 - i < 0) ? 0 : 8 - i);
      end
    end
    cyc(0, 0, 1, 1, 0, 1, 0);
    checks++;
    if (dut_vec !== vec(1, 1, 14, 0, 3, 0)) begin
      errors++; $display("FAIL updown_right got %h want %h", dut_vec, vec(1, 1, 14, 0, 3, 0));
    end
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (dut_vec !== vec(1, 19, 14, 0, 3, 0)) begin
      errors++; $display("FAIL clamp_right_down got %h want %h", dut_vec, vec(1, 19, 14, 0, 3, 0));
    end
    cyc(0, 0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    checks++;
    if (dut_vec !== vec(1, 19, 13, 0, 3, 0)) begin
      errors++; $display("FAIL vert_priority got %h want %h", dut_vec, vec(1, 19, 13, 0, 3, 0));
    end
  endtask

  task automatic test_goal_win();
    clear_obs();
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int g = 1; g <= WINS; g++) begin
      for (int i = 0; i < 14; i++) cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== vec(g == WINS ? 3 : 1, 9, 14, g, 3, g == WINS)) begin
        errors++; $display("FAIL goal%0d got %h want %h", g, dut_vec, vec(g == WINS ? 3 : 1, 9, 14, g, 3, g == WINS));
      end
    end
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 1, 0, 0);
    checks++;
    if (dut_vec !== vec(3, 9, 14, WINS, 3, 1)) begin
      errors++; $display("FAIL win_hold got %h want %h", dut_vec, vec(3, 9, 14, WINS, 3, 1));
    end
  endtask

  task automatic test_hit();
    clear_obs();
    obs[13] = 20'h1 << 9;
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== vec(1, 9, 13, 0, 3, 0)) begin
      errors++; $display("FAIL hit_pre got %h want %h", dut_vec, vec(1, 9, 13, 0, 3, 0));
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== vec(2, 9, 13, 0, 2, 0)) begin
      errors++; $display("FAIL hit_entry got %h want %h", dut_vec, vec(2, 9, 13, 0, 2, 0));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 1, 0);
    end
    checks++;
    if (dut_vec !== vec(2, 9, 13, 0, 2, 0)) begin
      errors++; $display("FAIL hit_frozen got %h want %h", dut_vec, vec(2, 9, 13, 0, 2, 0));
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== vec(1, 9, 14, 0, 2, 0)) begin
      errors++; $display("FAIL hit_exit got %h want %h", dut_vec, vec(1, 9, 14, 0, 2, 0));
    end
  endtask

  task automatic test_game_over();
    for (int h = 0; h < 2; h++) begin
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < HT; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    end
    checks++;
    if (dut_vec !== vec(3, 9, 13, 0, 0, 0)) begin
      errors++; $display("FAIL lose_done got %h want %h", dut_vec, vec(3, 9, 13, 0, 0, 0));
    end
    for (int i = 0; i < 10; i++) cyc($urandom_range(0, 1), 1, $urandom_range(0, 1), 0, 0, 1, 0);
    checks++;
    if (dut_vec !== vec(3, 9, 13, 0, 0, 0)) begin
      errors++; $display("FAIL lose_hold got %h want %h", dut_vec, vec(3, 9, 13, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid_hit();
    clear_obs();
    obs[13] = 20'h1 << 9;
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    checks++;
    if (dut_vec !== vec(0, 9, 14, 0, 3, 0)) begin
      errors++; $display("FAIL reset_mid_hit got %h want %h", dut_vec, vec(0, 9, 14, 0, 3, 0));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) obs[i] = $urandom & $urandom & $urandom;
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 299) == 0);
      if (m_state == 0 && $urandom_range(0, 3) == 0)
        for (int i = 0; i < 16; i++) obs[i] = $urandom & $urandom & $urandom;
      checks++;
      if (dut_vec !== exp_vec() || row_sel !== player_row) begin
        errors++; $display("FAIL random_cyc%0d got %h sel %0d want %h", n, dut_vec, row_sel, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_move_clamp();
    test_goal_win();
    test_hit();
    test_game_over();
    test_reset_mid_hit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
